load_store_unit: RTL and testbench

- Memory-access stage directly downstream of the ALU: takes the ALU result as effective address and performs one RISC-V load or store per request over a simple req/ack data-memory bus.
- Generates byte strobes and aligned write data; sign/zero-extends load data into a register-file-ready word.
- Detects misalignment, illegal width encodings and bus timeout.
- Multi-cycle: the core stalls while busy is high.

---
 rtl/lsu_pkg.sv | 31 +++
 rtl/lsu_align.sv | 56 +++++
 rtl/load_store_unit.sv | 142 ++++++++++++++
 tb/tb_load_store_unit.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit: width codes, FSM encoding,
// error codes and request-decode helpers.
package lsu_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_RESP = 2'd2
    } lsu_state_e;

    localparam logic [1:0] ERR_NONE     = 2'd0;
    localparam logic [1:0] ERR_MISALIGN = 2'd1;
    localparam logic [1:0] ERR_ILLEGAL  = 2'd2;
    localparam logic [1:0] ERR_BUS      = 2'd3;

    // Stores only exist in signed-looking widths; the unsigned codes are load-only.
    function automatic logic f3_illegal(input logic [2:0] f3, input logic is_st);
        return (f3 == 3'b011) || (f3 == 3'b110) || (f3 == 3'b111) || (is_st && f3[2]);
    endfunction

    function automatic logic f3_misaligned(input logic [2:0] f3, input logic [1:0] lo);
        return ((f3[1:0] == 2'b01) && lo[0]) || ((f3[1:0] == 2'b10) && (lo != 2'b00));
    endfunction

endpackage

// File: rtl/lsu_align.sv
// Byte-lane steering: store strobes and replicated write data, plus load
// extraction with sign/zero extension. Purely combinational.
module lsu_align
    import lsu_pkg::*;
(
    input  logic [2:0]  funct3_i,
    input  logic [1:0]  addr_lo_i,
    input  logic [31:0] store_data_i,
    input  logic [31:0] rdata_i,
    output logic [3:0]  wstrb_o,
    output logic [31:0] wdata_o,
    output logic [31:0] load_ext_o
);

    function automatic logic [31:0] sext8(input logic [7:0] b);
        logic signed [31:0] w;
        w = signed'({b, 24'd0}) >>> 24;
        return w;
    endfunction

    function automatic logic [31:0] sext16(input logic [15:0] h);
        logic signed [31:0] w;
        w = signed'({h, 16'd0}) >>> 16;
        return w;
    endfunction

    logic [31:0] shifted;

    always_comb begin
        shifted = rdata_i >> {addr_lo_i, 3'b000};

        case (funct3_i[1:0])
            2'b00: begin
                wstrb_o = 4'b0001 << addr_lo_i;
                wdata_o = {4{store_data_i[7:0]}};
            end
            2'b01: begin
                wstrb_o = 4'b0011 << addr_lo_i;
                wdata_o = {2{store_data_i[15:0]}};
            end
            default: begin
                wstrb_o = 4'b1111;
                wdata_o = store_data_i;
            end
        endcase

        case (funct3_i)
            F3_B:    load_ext_o = sext8(shifted[7:0]);
            F3_H:    load_ext_o = sext16(shifted[15:0]);
            F3_BU:   load_ext_o = {24'd0, shifted[7:0]};
            F3_HU:   load_ext_o = {16'd0, shifted[15:0]};
            default: load_ext_o = shifted;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// Memory-access stage: one RISC-V load or store per request over a req/ack
// data bus, with misalignment, illegal-encoding and bus-timeout detection.
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 16,
    parameter int ADDR_W         = 32
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              start,
    input  logic              is_store,
    input  logic [2:0]        funct3,
    input  logic [ADDR_W-1:0] addr,
    input  logic [31:0]       store_data,
    output logic              busy,
    output logic              done,
    output logic [31:0]       load_data,
    output logic              err_misalign,
    output logic              err_illegal,
    output logic              err_bus,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    output logic [3:0]        mem_wstrb,
    input  logic              mem_ack,
    input  logic [31:0]       mem_rdata
);

    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1) + 1;
    localparam logic [CNT_W-1:0] CNT_LAST =
        CNT_W'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);

    lsu_state_e         state_q, state_d;
    logic [1:0]         err_q, err_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [31:0]        load_q, load_d;
    logic               st_q;
    logic [2:0]         f3_q;
    logic [1:0]         alo_q;
    logic [ADDR_W-3:0]  ahi_q;
    logic [31:0]        sdata_q;

    logic [3:0]         strb;
    logic [31:0]        wdata;
    logic [31:0]        load_ext;
    logic               accept;

    assign accept = (state_q == ST_IDLE) && start;

    lsu_align u_align (
        .funct3_i     (f3_q),
        .addr_lo_i    (alo_q),
        .store_data_i (sdata_q),
        .rdata_i      (mem_rdata),
        .wstrb_o      (strb),
        .wdata_o      (wdata),
        .load_ext_o   (load_ext)
    );

    always_comb begin
        state_d = state_q;
        err_d   = err_q;
        cnt_d   = cnt_q;
        load_d  = load_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    cnt_d = '0;
                    if (f3_illegal(funct3, is_store)) begin
                        err_d   = ERR_ILLEGAL;
                        state_d = ST_RESP;
                    end else if (f3_misaligned(funct3, addr[1:0])) begin
                        err_d   = ERR_MISALIGN;
                        state_d = ST_RESP;
                    end else begin
                        err_d   = ERR_NONE;
                        state_d = ST_REQ;
                    end
                end
            end
            ST_REQ: begin
                // An ack in the expiring cycle still wins over the timeout.
                if (mem_ack) begin
                    state_d = ST_RESP;
                    if (!st_q) load_d = load_ext;
                end else if ((TIMEOUT_CYCLES != 0) && (cnt_q == CNT_LAST)) begin
                    err_d   = ERR_BUS;
                    state_d = ST_RESP;
                end else if (TIMEOUT_CYCLES != 0) begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_RESP: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q <= ST_IDLE;
            err_q   <= ERR_NONE;
            cnt_q   <= '0;
            load_q  <= '0;
        end else begin
            state_q <= state_d;
            err_q   <= err_d;
            cnt_q   <= cnt_d;
            load_q  <= load_d;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            st_q    <= 1'b0;
            f3_q    <= '0;
            alo_q   <= '0;
            ahi_q   <= '0;
            sdata_q <= '0;
        end else if (accept) begin
            st_q    <= is_store;
            f3_q    <= funct3;
            alo_q   <= addr[1:0];
            ahi_q   <= addr[ADDR_W-1:2];
            sdata_q <= store_data;
        end
    end

    assign busy         = (state_q == ST_REQ);
    assign done         = (state_q == ST_RESP);
    assign mem_req      = (state_q == ST_REQ);
    assign mem_we       = (state_q == ST_REQ) && st_q;
    assign mem_wstrb    = ((state_q == ST_REQ) && st_q) ? strb : 4'b0000;
    assign mem_wdata    = wdata;
    assign mem_addr     = {ahi_q, 2'b00};
    assign load_data    = load_q;
    assign err_misalign = done && (err_q == ERR_MISALIGN);
    assign err_illegal  = done && (err_q == ERR_ILLEGAL);
    assign err_bus      = done && (err_q == ERR_BUS);

endmodule

// File: tb/tb_load_store_unit.sv
// Randomized scoreboard bench for load_store_unit with a bus responder and
// a byte-level reference model.
module tb_load_store_unit;

    localparam int TO = 4;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic        start = 1'b0;
    logic        is_store = 1'b0;
    logic [2:0]  funct3 = 3'b000;
    logic [31:0] addr = '0;
    logic [31:0] store_data = '0;
    logic        busy, done, err_misalign, err_illegal, err_bus;
    logic [31:0] load_data;
    logic        mem_req, mem_we;
    logic [31:0] mem_addr, mem_wdata;
    logic [3:0]  mem_wstrb;
    logic        mem_ack = 1'b0;
    logic [31:0] mem_rdata = '0;

    load_store_unit #(.TIMEOUT_CYCLES(TO), .ADDR_W(32)) dut (
        .clk(clk), .resetn(resetn), .start(start), .is_store(is_store),
        .funct3(funct3), .addr(addr), .store_data(store_data),
        .busy(busy), .done(done), .load_data(load_data),
        .err_misalign(err_misalign), .err_illegal(err_illegal), .err_bus(err_bus),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb),
        .mem_ack(mem_ack), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        mis;
        logic        ill;
        logic        bus;
        logic [31:0] ld;
    } exp_t;

    exp_t        sbq[$];
    int          checks = 0;
    int          errors = 0;
    int          resp_delay = 0;
    logic [31:0] resp_rdata = '0;
    int          nreq = 0;
    int          req_cycle_cnt = 0;
    logic [31:0] exp_addr = '0;
    logic        exp_we = 1'b0;
    logic [3:0]  exp_wstrb = '0;
    logic [31:0] exp_wdata = '0;
    logic [31:0] model_load = '0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Bus responder: acks on the programmed REQ cycle (0 = never), injects
    // stray acks while idle, and checks the bus fields every REQ cycle.
    always @(posedge clk) begin
        #1;
        if (!resetn) begin
            mem_ack = 1'b0;
            nreq = 0;
        end else if (mem_req) begin
            nreq++;
            req_cycle_cnt++;
            chk("bus_busy", 32'(busy), 32'd1);
            chk("bus_addr", mem_addr, exp_addr);
            chk("bus_we", 32'(mem_we), 32'(exp_we));
            chk("bus_wstrb", 32'(mem_wstrb), 32'(exp_wstrb));
            if (exp_we) chk("bus_wdata", mem_wdata, exp_wdata);
            if (nreq == resp_delay) begin
                mem_ack = 1'b1;
                mem_rdata = resp_rdata;
            end else begin
                mem_ack = 1'b0;
                mem_rdata = $urandom;
            end
        end else begin
            nreq = 0;
            mem_ack = ($urandom_range(0, 7) == 0);
            mem_rdata = $urandom;
        end
    end

    // Monitor: every done pops one expectation.
    always @(negedge clk) begin : monitor
        exp_t e;
        if (resetn && done) begin
            if (sbq.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_done: got done=1 expected no pending request (t=%0t)", $time);
            end else begin
                e = sbq.pop_front();
                chk("err_misalign", 32'(err_misalign), 32'(e.mis));
                chk("err_illegal", 32'(err_illegal), 32'(e.ill));
                chk("err_bus", 32'(err_bus), 32'(e.bus));
                chk("load_data", load_data, e.ld);
                chk("busy_at_done", 32'(busy), 32'd0);
            end
        end
    end

    task automatic run_req(input logic st, input logic [2:0] f3, input logic [31:0] a,
                           input logic [31:0] sd, input int dly, input logic [31:0] rd,
                           input bit hold);
        int size, off, exp_lat, exp_req, lat;
        bit ill, mis, berr, got;
        longint unsigned mask, val;
        exp_t e;
        off  = int'(a[1:0]);
        size = (f3[1:0] == 2'b00) ? 1 : (f3[1:0] == 2'b01) ? 2 : 4;
        ill  = (f3 == 3'd3) || (f3 >= 3'd6) || (st && f3[2]);
        mis  = !ill && ((off % size) != 0);
        berr = !ill && !mis && ((dly == 0) || (dly > TO));
        if (!ill && !mis && !berr && !st) begin
            mask = (longint'(1) << (8 * size)) - 1;
            val  = (longint'(rd) >> (8 * off)) & mask;
            if (!f3[2] && (((val >> (8 * size - 1)) & 1) == 1)) val = val | ~mask;
            model_load = val[31:0];
        end
        exp_addr = a & 32'hFFFF_FFFC;
        exp_we   = st;
        for (int i = 0; i < 4; i++) begin
            exp_wstrb[i] = st && (i >= off) && (i < off + size);
            exp_wdata[8*i +: 8] = 8'(sd >> (8 * (i % size)));
        end
        exp_lat = (ill || mis) ? 1 : berr ? TO + 1 : dly + 1;
        exp_req = (ill || mis) ? 0 : berr ? TO : dly;
        e.mis = mis; e.ill = ill; e.bus = berr; e.ld = model_load;
        sbq.push_back(e);
        resp_delay = dly;
        resp_rdata = rd;
        @(posedge clk); #1;
        req_cycle_cnt = 0;
        start = 1'b1; is_store = st; funct3 = f3; addr = a; store_data = sd;
        @(posedge clk); #1;
        if (!hold) begin
            start = 1'b0; addr = $urandom; store_data = $urandom;
        end
        lat = 0; got = 0;
        for (int i = 0; i < 64; i++) begin
            @(negedge clk);
            lat++;
            if (done) begin got = 1; break; end
        end
        if (hold) start = 1'b0;
        if (!got) begin
            checks++; errors++;
            $display("FAIL done_timeout: got no done expected done within 64 cycles");
            void'(sbq.pop_front());
        end else begin
            chk("latency", 32'(lat), 32'(exp_lat));
            chk("req_cycles", 32'(req_cycle_cnt), 32'(exp_req));
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got no finish expected finish before 500us");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_mem_req", 32'(mem_req), 32'd0);
        chk("rst_mem_we", 32'(mem_we), 32'd0);
        chk("rst_errs", {29'd0, err_misalign, err_illegal, err_bus}, 32'd0);
        chk("rst_wstrb", 32'(mem_wstrb), 32'd0);
        chk("rst_addr", mem_addr, 32'd0);
        chk("rst_wdata", mem_wdata, 32'd0);
        chk("rst_load", load_data, 32'd0);
        @(negedge clk);
        resetn = 1'b1;

        // Directed cases
        run_req(1'b1, 3'b000, 32'h0000_1003, 32'h0000_00A5, 2, 32'h0, 1'b0);
        run_req(1'b0, 3'b001, 32'h0000_2002, 32'h0, 1, 32'h8001_1234, 1'b0);
        run_req(1'b0, 3'b101, 32'h0000_2002, 32'h0, 3, 32'h8001_1234, 1'b0);
        run_req(1'b0, 3'b000, 32'h0000_2001, 32'h0, 1, 32'h0000_7F00, 1'b0);
        run_req(1'b0, 3'b010, 32'h0000_3002, 32'h0, 1, 32'hDEAD_BEEF, 1'b0);
        run_req(1'b1, 3'b100, 32'h0000_3000, 32'h1234_5678, 1, 32'h0, 1'b0);
        run_req(1'b0, 3'b011, 32'h0000_3000, 32'h0, 1, 32'h0, 1'b0);
        run_req(1'b0, 3'b010, 32'h0000_3004, 32'h0, 0, 32'h0, 1'b0);
        run_req(1'b0, 3'b010, 32'h0000_3004, 32'h0, TO, 32'hCAFE_F00D, 1'b0);
        run_req(1'b1, 3'b001, 32'h0000_3006, 32'hABCD_9876, 1, 32'h0, 1'b0);

        // Reset during REQ
        resp_delay = 0;
        exp_addr = 32'h0000_4000; exp_we = 1'b0; exp_wstrb = 4'b0000;
        @(posedge clk); #1;
        start = 1'b1; is_store = 1'b0; funct3 = 3'b010; addr = 32'h0000_4000;
        @(posedge clk); #1;
        start = 1'b0;
        @(posedge clk); #3;
        resetn = 1'b0;
        #1;
        chk("abort_mem_req", 32'(mem_req), 32'd0);
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_done", 32'(done), 32'd0);
        repeat (2) @(negedge clk);
        resetn = 1'b1;
        model_load = '0;
        chk("abort_load", load_data, 32'd0);
        run_req(1'b0, 3'b010, 32'h0000_4000, 32'h0, 2, 32'h1357_9BDF, 1'b0);

        // start held through whole transactions
        run_req(1'b0, 3'b010, 32'h0000_5004, 32'h0, 2, 32'h2468_ACE0, 1'b1);
        run_req(1'b0, 3'b010, 32'h0000_5006, 32'h0, 2, 32'h0, 1'b1);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("idle_after_hold_req", 32'(mem_req), 32'd0);
        end

        // Random traffic
        for (int n = 0; n < 150; n++) begin
            int dly;
            dly = ($urandom_range(0, 9) == 0) ? 0 : int'($urandom_range(1, 6));
            run_req(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), $urandom,
                    $urandom, dly, $urandom, 1'($urandom_range(0, 3) == 0));
        end

        repeat (3) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
